// File: rtl/qcw_burst_sequencer.sv
// -----------------------------------------------------------------------------
// qcw_burst_sequencer
//
// Sequences one QCW burst of the resonant driver: accepts an armed fire
// request, latches the burst configuration, pulses qcw_start, ramps the phase
// shift once per completed resonant cycle, waits for the driver's done edge,
// then enforces a minimum idle holdoff before the next burst. Driver faults,
// over-current halts and a RUN watchdog latch the block in FAULT until the
// fault is acknowledged and both fault levels are gone.
//
// Ports
//   clk, reset            80 MHz clock, synchronous active-high reset
//   arm, fire_req         request gating level / single-cycle burst request
//   clear_fault           single-cycle fault acknowledge
//   cfg_cycle_limit       burst cycle count, latched at acceptance
//   cfg_phase_start       ramp start phase, latched at acceptance
//   cfg_phase_end         ramp ceiling (read live)
//   cfg_ramp_step         per-cycle phase increment (read live)
//   cfg_holdoff           idle clks after a burst (read live at burst end)
//   qcw_cycle_finished    one pulse per completed resonant cycle
//   qcw_done/fault/halt   driver done, driver fault, over-current halt levels
//   qcw_start             single-cycle start to the driver
//   qcw_cycle_limit       latched cycle limit
//   qcw_phase_shift       current phase shift
//   busy, fault_latched   status levels
//   fault_cause           01 driver fault, 10 halt, 11 watchdog timeout
//   burst_count           completed bursts (wrapping)
//   reject_count          dropped fire requests (saturating)
//
// State | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for an armed fire_req; accept_pend marks the latch cycle
// START | qcw_start asserted for this single cycle
// RUN   | burst in progress, phase ramp and watchdog active
// HOLDOFF | minimum idle time after a completed burst
// FAULT | latched fault, waits for clear_fault with faults gone
// -----------------------------------------------------------------------------
module qcw_burst_sequencer #(
    parameter int TIMEOUT_CYCLES = 800000,
    parameter int HOLDOFF_W      = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 fire_req,
    input  logic                 clear_fault,
    input  logic [15:0]          cfg_cycle_limit,
    input  logic [7:0]           cfg_phase_start,
    input  logic [7:0]           cfg_phase_end,
    input  logic [7:0]           cfg_ramp_step,
    input  logic [HOLDOFF_W-1:0] cfg_holdoff,
    input  logic                 qcw_cycle_finished,
    input  logic                 qcw_done,
    input  logic                 qcw_fault,
    input  logic                 qcw_halt,
    output logic                 qcw_start,
    output logic [15:0]          qcw_cycle_limit,
    output logic [7:0]           qcw_phase_shift,
    output logic                 busy,
    output logic                 fault_latched,
    output logic [1:0]           fault_cause,
    output logic [15:0]          burst_count,
    output logic [7:0]           reject_count
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        RUN     = 3'd2,
        HOLDOFF = 3'd3,
        FAULT   = 3'd4
    } state_t;

    state_t               state;
    logic                 accept_pend;
    logic                 done_prev;
    logic [7:0]           phase_start_q;
    logic [WD_W-1:0]      wd_cnt;
    logic [HOLDOFF_W-1:0] holdoff_cnt;

    logic       accept;
    logic       done_rise;
    logic [8:0] phase_sum;
    logic [7:0] phase_next;

    // accept_pend blocks a second request during the latch cycle
    assign accept    = (state == IDLE) && !accept_pend && arm && fire_req;
    assign done_rise = qcw_done && !done_prev;

    // Sum kept 9 bits wide so a large step saturates at the end value
    // instead of wrapping. An inverted ramp (end below start) parks the
    // phase at the latched start value.
    always_comb begin
        phase_sum = {1'b0, qcw_phase_shift} + {1'b0, cfg_ramp_step};
        if (cfg_phase_end < phase_start_q) begin
            phase_next = phase_start_q;
        end else if (phase_sum > {1'b0, cfg_phase_end}) begin
            phase_next = cfg_phase_end;
        end else begin
            phase_next = phase_sum[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            accept_pend     <= 1'b0;
            done_prev       <= 1'b0;
            phase_start_q   <= '0;
            wd_cnt          <= '0;
            holdoff_cnt     <= '0;
            qcw_start       <= 1'b0;
            qcw_cycle_limit <= '0;
            qcw_phase_shift <= '0;
            busy            <= 1'b0;
            fault_latched   <= 1'b0;
            fault_cause     <= 2'b00;
            burst_count     <= '0;
            reject_count    <= '0;
        end else begin
            done_prev <= qcw_done;
            qcw_start <= 1'b0;

            if (fire_req && !accept && (reject_count != 8'hFF)) begin
                reject_count <= reject_count + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (accept_pend) begin
                        accept_pend <= 1'b0;
                        state       <= START;
                        qcw_start   <= 1'b1;
                        busy        <= 1'b1;
                    end else if (accept) begin
                        accept_pend     <= 1'b1;
                        qcw_cycle_limit <= cfg_cycle_limit;
                        qcw_phase_shift <= cfg_phase_start;
                        phase_start_q   <= cfg_phase_start;
                    end
                end

                START: begin
                    if (qcw_fault) begin
                        state         <= FAULT;
                        fault_latched <= 1'b1;
                        fault_cause   <= 2'b01;
                    end else if (qcw_halt) begin
                        state         <= FAULT;
                        fault_latched <= 1'b1;
                        fault_cause   <= 2'b10;
                    end else begin
                        state  <= RUN;
                        wd_cnt <= '0;
                    end
                end

                RUN: begin
                    if (qcw_fault) begin
                        state         <= FAULT;
                        fault_latched <= 1'b1;
                        fault_cause   <= 2'b01;
                    end else if (qcw_halt) begin
                        state         <= FAULT;
                        fault_latched <= 1'b1;
                        fault_cause   <= 2'b10;
                    end else if (done_rise) begin
                        // a cycle_finished in the same clk is dropped
                        state       <= HOLDOFF;
                        holdoff_cnt <= cfg_holdoff;
                        burst_count <= burst_count + 16'd1;
                    end else if (wd_cnt == WD_LAST) begin
                        state         <= FAULT;
                        fault_latched <= 1'b1;
                        fault_cause   <= 2'b11;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (qcw_cycle_finished) begin
                            qcw_phase_shift <= phase_next;
                        end
                    end
                end

                HOLDOFF: begin
                    if (holdoff_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        holdoff_cnt <= holdoff_cnt - 1'b1;
                    end
                end

                FAULT: begin
                    if (clear_fault && !qcw_fault && !qcw_halt) begin
                        state           <= IDLE;
                        busy            <= 1'b0;
                        fault_latched   <= 1'b0;
                        fault_cause     <= 2'b00;
                        qcw_phase_shift <= '0;
                    end
                end

                default: begin
                    state         <= FAULT;
                    busy          <= 1'b1;
                    fault_latched <= 1'b1;
                    fault_cause   <= 2'b11;
                end
            endcase
        end
    end

endmodule
